// File: rtl/hash_arbiter.sv
// hash_arbiter
//   Round-robin arbiter that shares one byte-sum hash unit between NUM_REQ
//   requesters. The winner's key is latched and presented to the hash unit
//   over a level start/ready handshake. Each result goes back to its
//   requester as a one-cycle response pulse. A watchdog aborts a hash that
//   never reports ready.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_i           level request per requester, held until answered
//   key_i           flat keys, requester k at [64k+63:64k]
//   gnt_o           one-hot grant, latch cycle through RESP
//   resp_valid_o    one-cycle response pulse
//   resp_id_o       index of requester being answered
//   resp_val_o      hash result (0 on timeout)
//   resp_err_o      timeout abort flag
//   busy_o          high whenever not IDLE
//   hash_start_o    level start to hash unit
//   hash_key_o      key to hash unit
//   hash_ready_i    hash unit ready
//   hash_val_i      hash unit result
module hash_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*64-1:0] key_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic                  resp_valid_o,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [31:0]           resp_val_o,
  output logic                  resp_err_o,
  output logic                  busy_o,
  output logic                  hash_start_o,
  output logic [63:0]           hash_key_o,
  input  logic                  hash_ready_i,
  input  logic [31:0]           hash_val_i
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_RELEASE
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       resp_id_q, resp_id_d;
  logic [63:0]           key_q, key_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [31:0]           val_q, val_d;
  logic                  err_q, err_d;

  logic                  pick_found;
  logic [ID_W-1:0]       pick_id;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [63:0]           pick_key;
  logic [WD_W-1:0]       wdog_inc;

  // Round-robin pick: scan offsets last+1, last+2, ... with wrap; the
  // first requester found at the smallest offset wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_gnt   = '0;
    pick_key   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_found && req_i[j] && (j == (int'(last_q) + off) % NUM_REQ)) begin
          pick_found  = 1'b1;
          pick_id     = ID_W'(j);
          pick_gnt[j] = 1'b1;
          pick_key    = key_i[64*j +: 64];
        end
      end
    end
  end

  // Saturating watchdog increment
  assign wdog_inc = (wdog_q == WD_W'(TIMEOUT)) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    resp_id_d = resp_id_q;
    key_d     = key_q;
    gnt_d     = gnt_q;
    wdog_d    = wdog_q;
    val_d     = val_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_gnt;
          id_d    = pick_id;
          key_d   = pick_key;
          state_d = S_ISSUE;
        end
      end
      // Ready is not looked at here: it may still be high from the last job.
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hash_ready_i) begin
          val_d     = hash_val_i;
          err_d     = 1'b0;
          resp_id_d = id_q;
          state_d   = S_RESP;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WD_W'(TIMEOUT)) begin
            val_d     = '0;
            err_d     = 1'b1;
            resp_id_d = id_q;
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: begin
        last_d  = id_q;
        gnt_d   = '0;
        state_d = S_RELEASE;
      end
      // One low-start cycle so the hash unit can return to its free state.
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      resp_id_q <= '0;
      key_q     <= '0;
      gnt_q     <= '0;
      wdog_q    <= '0;
      val_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      key_q     <= key_d;
      gnt_q     <= gnt_d;
      wdog_q    <= wdog_d;
      val_q     <= val_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_id_o    = resp_id_q;
  assign resp_val_o   = val_q;
  assign resp_err_o   = err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign hash_start_o = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign hash_key_o   = key_q;

endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter
//   Directed bench for hash_arbiter with a byte-sum hash unit model and a
//   response scoreboard (id, value, error flag, response cycle).
module tb_hash_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;

  localparam logic [63:0] K0  = 64'h0102030405060708;
  localparam logic [63:0] K1  = 64'h1111111111111111;
  localparam logic [63:0] K2  = 64'hFF00FF00FF00FF00;
  localparam logic [63:0] K3  = 64'h0A0B0C0D0E0F1011;
  localparam logic [63:0] K2B = 64'h0000000000000001;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*64-1:0] key_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic                  resp_valid_o;
  logic [ID_W-1:0]       resp_id_o;
  logic [31:0]           resp_val_o;
  logic                  resp_err_o;
  logic                  busy_o;
  logic                  hash_start_o;
  logic [63:0]           hash_key_o;
  logic                  hash_ready_i;
  logic [31:0]           hash_val_i;

  hash_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .key_i(key_i), .gnt_o(gnt_o),
    .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_val_o(resp_val_o),
    .resp_err_o(resp_err_o), .busy_o(busy_o), .hash_start_o(hash_start_o),
    .hash_key_o(hash_key_o), .hash_ready_i(hash_ready_i), .hash_val_i(hash_val_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] bytesum(input logic [63:0] k);
    logic [31:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) s = s + {24'd0, k[8*b +: 8]};
    return s;
  endfunction

  // Hash unit model. mode 0: ready on the third start cycle.
  // mode 1: ready stuck high; a stale value is shown during the first start
  // cycle and the real hash afterwards. mode 2: never ready.
  int   mode = 0;
  int   hcnt = 0;
  always @(posedge clk) hcnt <= hash_start_o ? hcnt + 1 : 0;
  always_comb begin
    hash_ready_i = 1'b0;
    hash_val_i   = 32'h5555_5555;
    case (mode)
      0: begin
        hash_ready_i = hash_start_o && (hcnt == 2);
        hash_val_i   = hash_ready_i ? bytesum(hash_key_o) : 32'hBAD0_0BAD;
      end
      1: begin
        hash_ready_i = 1'b1;
        hash_val_i   = (hash_start_o && hcnt >= 1) ? bytesum(hash_key_o) : 32'hDEAD_BEEF;
      end
      default: ;
    endcase
  end

  typedef struct {
    int          id;
    logic [31:0] val;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    chk("gnt_onehot0", {63'd0, $onehot0(gnt_o)}, 64'd1);
    if (resp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {63'd0, resp_valid_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_id",    {62'd0, resp_id_o}, e.id);
        chk("resp_val",   {32'd0, resp_val_o}, {32'd0, e.val});
        chk("resp_err",   {63'd0, resp_err_o}, {63'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] keyof(input int id);
    return key_i[64*id +: 64];
  endfunction

  // Single request with the standard hash model; assumes IDLE on entry.
  task automatic serve(input int id, input logic [63:0] k);
    int c0;
    c0 = cyc;
    key_i[64*id +: 64] = k;
    req_i[id] = 1'b1;
    sb.push_back('{id, bytesum(k), 1'b0, c0 + 4});
    repeat (4) tick();
    req_i = '0;
    repeat (2) tick();
  endtask

  int c0;

  initial begin
    rst   = 1'b1;
    req_i = '0;
    key_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",        {60'd0, gnt_o}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
    chk("rst_resp_id",    {62'd0, resp_id_o}, 64'd0);
    chk("rst_resp_val",   {32'd0, resp_val_o}, 64'd0);
    chk("rst_resp_err",   {63'd0, resp_err_o}, 64'd0);
    chk("rst_busy",       {63'd0, busy_o}, 64'd0);
    chk("rst_hash_start", {63'd0, hash_start_o}, 64'd0);
    chk("rst_hash_key",   hash_key_o, 64'd0);
    rst = 1'b0;
    tick();

    // Single request, standard 3-cycle hash
    c0 = cyc;
    key_i[63:0] = K0;
    req_i = 4'b0001;
    sb.push_back('{0, 32'h24, 1'b0, c0 + 4});
    tick();
    chk("single_start_c1", {63'd0, hash_start_o}, 64'd1);
    chk("single_gnt",      {60'd0, gnt_o}, 64'b0001);
    chk("single_key",      hash_key_o, K0);
    tick();
    chk("single_start_c2", {63'd0, hash_start_o}, 64'd1);
    tick();
    chk("single_start_c3", {63'd0, hash_start_o}, 64'd1);
    tick();
    chk("single_resp_c4",  {63'd0, resp_valid_o}, 64'd1);
    chk("single_start_c4", {63'd0, hash_start_o}, 64'd0);
    req_i = '0;
    tick();
    chk("release_start",   {63'd0, hash_start_o}, 64'd0);
    chk("release_busy",    {63'd0, busy_o}, 64'd1);
    chk("release_gnt",     {60'd0, gnt_o}, 64'd0);
    tick();
    chk("idle_busy",       {63'd0, busy_o}, 64'd0);
    chk("val_hold",        {32'd0, resp_val_o}, 64'h24);

    // Stale ready: ready stays high through ISSUE
    mode = 1;
    c0 = cyc;
    key_i[127:64] = K1;
    req_i = 4'b0010;
    sb.push_back('{1, bytesum(K1), 1'b0, c0 + 3});
    tick();
    chk("stale_issue_noresp", {63'd0, resp_valid_o}, 64'd0);
    repeat (2) tick();
    chk("stale_resp_c3", {63'd0, resp_valid_o}, 64'd1);
    req_i = '0;
    mode = 0;
    repeat (2) tick();

    // Timeout, then a normal service
    mode = 2;
    c0 = cyc;
    key_i[191:128] = K2;
    req_i = 4'b0100;
    sb.push_back('{2, 32'd0, 1'b1, c0 + 2 + TIMEOUT});
    repeat (TIMEOUT + 2) tick();
    chk("timeout_resp", {63'd0, resp_valid_o}, 64'd1);
    chk("timeout_err",  {63'd0, resp_err_o}, 64'd1);
    req_i = '0;
    mode = 0;
    repeat (2) tick();
    serve(3, K3);
    chk("after_timeout_err", {63'd0, resp_err_o}, 64'd0);

    // All requesters continuously; ready on first WAIT cycle -> 5-cycle period
    mode = 1;
    key_i = {K3, K2, K1, K0};
    c0 = cyc;
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++)
      sb.push_back('{i % 4, bytesum(keyof(i % 4)), 1'b0, c0 + 3 + 5 * i});
    repeat (23) tick();
    chk("rr_last_resp", {63'd0, resp_valid_o}, 64'd1);
    req_i = '0;
    mode = 0;
    repeat (2) tick();

    // Withdrawal and key change after grant
    c0 = cyc;
    key_i[191:128] = K2;
    req_i = 4'b0100;
    sb.push_back('{2, bytesum(K2), 1'b0, c0 + 4});
    tick();
    req_i[2] = 1'b0;
    key_i[191:128] = K2B;
    repeat (3) tick();
    chk("withdraw_resp", {63'd0, resp_valid_o}, 64'd1);
    req_i = 4'b1001;
    sb.push_back('{3, bytesum(K3), 1'b0, c0 + 10});
    sb.push_back('{0, bytesum(K0), 1'b0, c0 + 16});
    repeat (6) tick();
    req_i = 4'b0001;
    repeat (6) tick();
    req_i = '0;
    repeat (2) tick();

    // Reset while in WAIT
    mode = 2;
    req_i = 4'b0010;
    repeat (2) tick();
    chk("prereset_start", {63'd0, hash_start_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_start", {63'd0, hash_start_o}, 64'd0);
    chk("midrst_gnt",   {60'd0, gnt_o}, 64'd0);
    chk("midrst_busy",  {63'd0, busy_o}, 64'd0);
    @(posedge clk);
    #1;
    chk("midrst_busy2", {63'd0, busy_o}, 64'd0);
    rst = 1'b0;
    mode = 0;
    c0 = cyc;
    req_i = 4'b0011;
    sb.push_back('{0, bytesum(K0), 1'b0, c0 + 4});
    tick();
    chk("postrst_gnt", {60'd0, gnt_o}, 64'b0001);
    repeat (3) tick();
    req_i = 4'b0010;
    sb.push_back('{1, bytesum(K1), 1'b0, c0 + 10});
    repeat (6) tick();
    req_i = '0;
    repeat (4) tick();

    chk("sb_empty", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hash_arbiter.md
Name: hash_arbiter

Overview:
- Shares the single byte-sum hash unit between NUM_REQ requesters, e.g. parser lookup and table-update paths.
- Arbitration is round-robin. The block latches the winner's key and drives the hash unit's level start/ready handshake.
- Each result is returned to its requester with a one-cycle response pulse.
- A watchdog aborts a hash that never reports ready.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index, equal to clog2(NUM_REQ)
TIMEOUT, 16, max cycles spent in WAIT before abort (at least 4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_i  in  NUM_REQ  level request per requester; held until its resp_valid_o
key_i  in  NUM_REQ*64  flat keys; requester k occupies bits [64k+63:64k]
gnt_o  out  NUM_REQ  one-hot grant, high from latch cycle through RESP
resp_valid_o  out  1  one-cycle response pulse
resp_id_o  out  ID_W  index of the requester being answered
resp_val_o  out  32  hash result
resp_err_o  out  1  timeout abort flag, qualified by resp_valid_o
busy_o  out  1  high whenever state is not IDLE
hash_start_o  out  1  level start to hash unit
hash_key_o  out  64  key to hash unit, stable while hash_start_o is high
hash_ready_i  in  1  hash unit ready
hash_val_i  in  32  hash unit result

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
  - Latched key, latched id and watchdog counter are 0.
- States: IDLE, ISSUE, WAIT, RESP, RELEASE.
- IDLE:
  - If req_i is nonzero, select the first set bit searching last+1, last+2, ... with wrap.
  - Register gnt_o one-hot, latched id and latched key = key_i slice; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - hash_start_o=1 and hash_key_o=latched key.
  - hash_ready_i is ignored in this cycle, because a stale ready from the previous job may still be high.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - hash_start_o stays 1.
  - If hash_ready_i=1: capture hash_val_i, resp_err=0, go to RESP.
  - Otherwise increment the watchdog. When the watchdog reaches TIMEOUT: result=0, resp_err=1, go to RESP.
  - Ready and timeout in the same cycle: ready wins.
- RESP (1 cycle):
  - resp_valid_o=1 with resp_id_o, resp_val_o and resp_err_o.
  - hash_start_o=0; last = latched id.
  - gnt_o clears at the end of this cycle. Go to RELEASE.
- RELEASE (1 cycle):
  - hash_start_o=0, giving the hash unit a low-start cycle to return to its free state.
  - Go to IDLE.
- Only IDLE samples req_i, so a single requester is served at most once every 5 cycles.
- Latency: request seen in IDLE at cycle 0 -> start high at cycle 1 -> resp_valid at cycle 3+D, where D is the number of WAIT cycles before ready. With the standard 3-cycle hash unit, resp_valid is at cycle 4.
- resp_val_o and resp_err_o hold their values until the next RESP. resp_id_o also holds.
- Request deasserted during service: the job still completes and the response is still issued. The requester must discard it.
- key_i changes after the latch cycle: ignored, because the latched key is used.
- New requests arriving while busy wait. No request is lost as long as the requester holds req_i.
- Fairness: each set request is served within NUM_REQ services.
- Reset asserted mid-operation:
  - Immediate return to IDLE; all outputs go to 0, including hash_start_o.
  - No response is issued for the in-flight job.
- The watchdog counter saturates and does not wrap.

Test Plan:
- Single request: req_i=0001, key0=0x0102030405060708, hash model with 3-cycle ready -> hash_start_o high for 3 cycles, resp_valid at cycle 4, resp_id=0, resp_val=0x24, err=0.
- All requesters continuously: req_i=1111 held -> resp_id sequence 0,1,2,3,0; consecutive responses exactly 5 cycles apart; gnt_o is always one-hot.
- Stale ready: hash_ready_i stuck at 1 from the previous job -> ISSUE ignores it; response comes from WAIT at cycle 3 with the new value, never the old one.
- Timeout: hash_ready_i held at 0 -> resp_valid exactly TIMEOUT WAIT cycles after entering WAIT, with resp_err=1 and resp_val=0; the next request is then served normally.
- Withdrawal and key change: requester 2 drops req and changes key the cycle after grant -> response for id 2 still issued with the hash of the original key; pointer advances so requester 3 is served next.
- Reset mid-WAIT: assert rst -> hash_start_o, gnt_o and busy_o are 0 immediately; no resp_valid; after release, requester 0 has priority again.
